// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and the baud-rate period table,
// derived from the system clock frequency.
package uart_pkg;

  localparam int DEFAULT_BAUD_IDX = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  typedef logic [15:0][31:0] baud_tbl_t;

  // Indices 12..15 are unused selections and fall back to 115200.
  function automatic int unsigned baud_rate(input logic [3:0] idx);
    case (idx)
      4'd0:    return 300;
      4'd1:    return 1200;
      4'd2:    return 2400;
      4'd3:    return 4800;
      4'd4:    return 9600;
      4'd5:    return 19200;
      4'd6:    return 38400;
      4'd7:    return 57600;
      4'd8:    return 115200;
      4'd9:    return 230400;
      4'd10:   return 460800;
      4'd11:   return 921600;
      default: return 115200;
    endcase
  endfunction

  // Bit period in clocks, rounded to nearest; evaluated at elaboration only.
  function automatic baud_tbl_t baud_table(input int unsigned clk_hz);
    baud_tbl_t tbl;
    for (int unsigned i = 0; i < 16; i++) begin
      tbl[i[3:0]] = (clk_hz + baud_rate(i[3:0]) / 2) / baud_rate(i[3:0]);
    end
    return tbl;
  endfunction

endpackage

// File: rtl/uart_rx_bittmr.sv
// Loadable bit-period down-counter. expire is high for the single cycle in
// which the count is 1, so an action taken on expire lands N clocks after a load of N.
module uart_rx_bittmr #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_half,
  input  logic             load_full,
  input  logic [CNT_W-1:0] period,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_half) begin
      cnt_d = period >> 1;
    end else if (load_full) begin
      cnt_d = period;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronises rx, samples each bit at mid-period and
// commits the character with sticky ready/error flags for the register logic.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int CNT_W  = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       parity_en,
  input  logic       ohel,
  input  logic       rx,
  input  logic       rd_clr,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf,
  output logic       busy
);

  localparam baud_tbl_t PERIOD_TBL = baud_table(CLK_HZ);

  logic             sync1_q, rxs;
  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             eight_q, eight_d;
  logic             par_en_q, par_en_d;
  logic             ohel_q, ohel_d;
  logic             perr_pend_q, perr_pend_d;
  logic             stop_bad_q, stop_bad_d;
  logic             commit_q, commit_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_rdy_q, rx_rdy_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] table_period;
  logic [CNT_W-1:0] tmr_period;
  logic             load_half, load_full, expire;
  logic [2:0]       last_bit;
  logic             data_par;

  // In IDLE the configuration is not latched yet, so the half-period load
  // must come straight from the live baud select.
  assign table_period = PERIOD_TBL[baud][CNT_W-1:0];
  assign tmr_period   = (state_q == IDLE) ? table_period : period_q;
  assign last_bit     = eight_q ? 3'd7 : 3'd6;
  assign data_par     = eight_q ? ^shift_q : ^shift_q[7:1];

  uart_rx_bittmr #(.CNT_W(CNT_W)) u_bittmr (
    .clk       (clk),
    .rst       (rst),
    .load_half (load_half),
    .load_full (load_full),
    .period    (tmr_period),
    .expire    (expire)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    period_d    = period_q;
    eight_d     = eight_q;
    par_en_d    = par_en_q;
    ohel_d      = ohel_q;
    perr_pend_d = perr_pend_q;
    stop_bad_d  = stop_bad_q;
    commit_d    = 1'b0;
    load_half   = 1'b0;
    load_full   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d     = START;
          load_half   = 1'b1;
          period_d    = table_period;
          eight_d     = eight;
          par_en_d    = parity_en;
          ohel_d      = ohel;
          bit_cnt_d   = 3'd0;
          perr_pend_d = 1'b0;
        end
      end
      START: begin
        if (expire) begin
          if (!rxs) begin
            state_d   = DATA;
            load_full = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_d   = {rxs, shift_q[7:1]};
          load_full = 1'b1;
          if (bit_cnt_q == last_bit) begin
            bit_cnt_d = 3'd0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (expire) begin
          perr_pend_d = rxs ^ data_par ^ ohel_q;
          load_full   = 1'b1;
          state_d     = STOP;
        end
      end
      STOP: begin
        if (expire) begin
          commit_d   = 1'b1;
          stop_bad_d = !rxs;
          state_d    = rxs ? IDLE : BRK_WAIT;
        end
      end
      BRK_WAIT: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reader handshake: rx_rdy stays high until a one-cycle rd_clr; a commit in
  // the same cycle as rd_clr wins, and only an unread character raises ovf.
  always_comb begin
    rx_data_d = rx_data_q;
    rx_rdy_d  = rx_rdy_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovf_d     = ovf_q;
    if (rd_clr) begin
      rx_rdy_d = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      ovf_d    = 1'b0;
    end
    if (commit_q) begin
      rx_data_d = eight_q ? shift_q : {1'b0, shift_q[7:1]};
      rx_rdy_d  = 1'b1;
      perr_d    = perr_pend_q;
      ferr_d    = stop_bad_q;
      ovf_d     = rx_rdy_q & ~rd_clr;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      rxs         <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      period_q    <= '0;
      eight_q     <= 1'b0;
      par_en_q    <= 1'b0;
      ohel_q      <= 1'b0;
      perr_pend_q <= 1'b0;
      stop_bad_q  <= 1'b0;
      commit_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_rdy_q    <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= rx;
      rxs         <= sync1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      period_q    <= period_d;
      eight_q     <= eight_d;
      par_en_q    <= par_en_d;
      ohel_q      <= ohel_d;
      perr_pend_q <= perr_pend_d;
      stop_bad_q  <= stop_bad_d;
      commit_q    <= commit_d;
      rx_data_q   <= rx_data_d;
      rx_rdy_q    <= rx_rdy_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_rdy  = rx_rdy_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;

endmodule
